// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared M-extension divide encodings and FSM states
package alu_div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

endpackage

// File: rtl/alu_div.sv
// rtl/alu_div.sv - multi-cycle restoring divider for DIV/DIVU/REM/REMU
module alu_div
  import alu_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] div_dividend,
  input  logic [XLEN-1:0] div_divisor,
  input  logic [4:0]      div_rd,
  input  logic            flush,
  output logic            div_busy,
  output logic            div_done,
  output logic [XLEN-1:0] div_result,
  output logic [4:0]      div_rd_o,
  output logic            div_wr_en_o
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [2*XLEN-1:0] rq_q, rq_d;

  logic              in_signed;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] shifted;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix, res;
  logic              accept;

  always_comb begin
    in_signed = op_is_signed(div_op);
    mag_a     = (in_signed && div_dividend[XLEN-1]) ? -div_dividend : div_dividend;
    mag_b     = (in_signed && div_divisor[XLEN-1])  ? -div_divisor  : div_divisor;
    accept    = (state_q == DIV_IDLE) && div_start && !flush;
    shifted   = {rq_q[2*XLEN-2:0], 1'b0};
    diff      = {1'b0, shifted[2*XLEN-1:XLEN]} - {1'b0, divisor_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    special_d = special_q;
    divisor_d = divisor_q;
    rq_d      = rq_q;
    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          op_d      = div_op;
          rd_d      = div_rd;
          sign_a_d  = in_signed && div_dividend[XLEN-1];
          sign_b_d  = in_signed && div_divisor[XLEN-1];
          divisor_d = mag_b;
          cnt_d     = '0;
          // Special cases park the final raw answer in rq and bypass the sign fix-up.
          if (div_divisor == '0) begin
            rq_d      = {div_dividend, {XLEN{1'b1}}};
            special_d = 1'b1;
            state_d   = DIV_DONE;
          end else if (in_signed && div_dividend == MIN_NEG && div_divisor == '1) begin
            rq_d      = {{XLEN{1'b0}}, MIN_NEG};
            special_d = 1'b1;
            state_d   = DIV_DONE;
          end else begin
            rq_d      = {{XLEN{1'b0}}, mag_a};
            special_d = 1'b0;
            state_d   = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rq_d  = diff[XLEN] ? shifted : {diff[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
      divisor_q <= '0;
      rq_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      special_q <= special_d;
      divisor_q <= divisor_d;
      rq_q      <= rq_d;
    end
  end

  always_comb begin
    quo     = rq_q[XLEN-1:0];
    rem     = rq_q[2*XLEN-1:XLEN];
    quo_fix = (sign_a_q ^ sign_b_q) ? -quo : quo;
    rem_fix = sign_a_q ? -rem : rem;
    if (special_q) res = op_is_rem(op_q) ? rem : quo;
    else           res = op_is_rem(op_q) ? rem_fix : quo_fix;
    div_busy    = accept || (state_q == DIV_CALC);
    div_done    = (state_q == DIV_DONE) && !flush;
    div_wr_en_o = div_done;
    div_result  = div_done ? res : '0;
    div_rd_o    = div_done ? rd_q : 5'd0;
  end

endmodule

// File: tb/tb_alu_div.sv
// tb/tb_alu_div.sv - randomized self-checking bench for alu_div
module tb_alu_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_start;
  logic [1:0]  div_op;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [4:0]  div_rd;
  logic        flush;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_result;
  logic [4:0]  div_rd_o;
  logic        div_wr_en_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_div #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .div_start(div_start), .div_op(div_op),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_rd(div_rd),
    .flush(flush), .div_busy(div_busy), .div_done(div_done),
    .div_result(div_result), .div_rd_o(div_rd_o), .div_wr_en_o(div_wr_en_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    logic [31:0] exp_res, res;
    int exp_lat, lat, busy_cnt;
    logic [4:0] rdo;
    logic we, busy_at_done;
    bit got;
    exp_res = ref_div(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : 33;
    @(negedge clk);
    div_start = 1'b1; div_op = op; div_dividend = a; div_divisor = b; div_rd = rd;
    #1;
    busy_cnt = div_busy ? 1 : 0;
    got = 0; lat = 0; res = '0; rdo = '0; we = 1'b0; busy_at_done = 1'b1;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      #1;
      if (div_done) begin
        got = 1; lat = c; res = div_result; rdo = div_rd_o; we = div_wr_en_o;
        busy_at_done = div_busy;
        div_start = 1'b0;
      end else if (div_busy) begin
        busy_cnt++;
      end
    end
    div_start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("latency", lat, exp_lat);
    check("result", res, exp_res);
    check("rd_o", 32'(rdo), 32'(rd));
    check("wr_en", 32'(we), 32'd1);
    check("busy_cycles", busy_cnt, exp_lat);
    check("busy_in_done", 32'(busy_at_done), 32'd0);
  endtask

  task automatic expect_no_done(input string tag);
    int seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (div_done) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(div_busy), 32'd0);
    check({tag, "_done"}, 32'(div_done), 32'd0);
    check({tag, "_result"}, div_result, 32'd0);
    check({tag, "_rd"}, 32'(div_rd_o), 32'd0);
    check({tag, "_wren"}, 32'(div_wr_en_o), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    rst_n = 1'b0; div_start = 1'b0; div_op = '0; div_dividend = '0;
    div_divisor = '0; div_rd = '0; flush = 1'b0;
    #2;
    check_outputs_zero("in_reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs_zero("after_reset");

    run_op(2'b01, 32'd100, 32'd7, 5'd11);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op(2'b00, 32'd5, 32'd0, 5'd6);
    run_op(2'b11, 32'd5, 32'd0, 5'd7);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd10);

    // Flush during CALC cycle 10
    @(negedge clk);
    div_start = 1'b1; div_op = 2'b01; div_dividend = 32'd1000; div_divisor = 32'd3; div_rd = 5'd12;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    flush = 1'b1; div_start = 1'b0;
    #1;
    check("flush_cycle_done", 32'(div_done), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_next_busy", 32'(div_busy), 32'd0);
    expect_no_done("flush_no_done");
    run_op(2'b01, 32'd9, 32'd3, 5'd13);

    // Flush coinciding with DONE of a special-case op
    @(negedge clk);
    div_start = 1'b1; div_op = 2'b00; div_dividend = 32'd5; div_divisor = 32'd0; div_rd = 5'd14;
    @(negedge clk);
    flush = 1'b1; div_start = 1'b0;
    #1;
    check("flush_done_done", 32'(div_done), 32'd0);
    check("flush_done_result", div_result, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    expect_no_done("flush_done_no_done");

    // Reset during CALC cycle 20
    @(negedge clk);
    div_start = 1'b1; div_op = 2'b01; div_dividend = 32'd12345; div_divisor = 32'd7; div_rd = 5'd15;
    for (int c = 1; c <= 20; c++) @(negedge clk);
    div_start = 1'b0; rst_n = 1'b0;
    #1;
    check_outputs_zero("calc_reset");
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_done("reset_no_done");

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = -32'($urandom_range(0, 200));
      run_op(op, a, b, 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_div.md
ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 Parameter XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 div_start  input  1  ALU request for a DIV/DIVU/REM/REMU op; held high while stalled.
REQ-005 div_op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 div_dividend  input  32  rs1 value.
REQ-007 div_divisor  input  32  rs2 value.
REQ-008 div_rd  input  5  destination register.
REQ-009 flush  input  1  pipeline flush from ctrl on a taken jump; aborts the op.
REQ-010 div_busy  output  1  stall request to ctrl.
REQ-011 div_done  output  1  one-cycle result-valid pulse.
REQ-012 div_result  output  32  quotient or remainder.
REQ-013 div_rd_o  output  5  latched rd, valid with div_done.
REQ-014 div_wr_en_o  output  1  register write enable, equal to div_done.

Function
REQ-015 FSM states: IDLE, CALC, DONE; encodings 0, 1, 2.
REQ-016 Accept: in IDLE with div_start=1 and flush=0, latch op, rd, operand signs and operand magnitudes.
- Magnitudes are absolute values for DIV/REM and raw values for DIVU/REMU.
REQ-017 div_busy = (IDLE & div_start & ~flush) | CALC, combinational; low in DONE so the pipeline advances that cycle.
REQ-018 Special cases move IDLE -> DONE directly.
- Divisor 0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = dividend.
- DIV/REM with 0x80000000 / 0xFFFFFFFF: DIV result 0x80000000; REM result 0.
REQ-019 Normal case moves IDLE -> CALC.
- CALC performs 32 restoring shift-subtract iterations, one quotient bit per cycle, counted by a 5-bit counter.
- CALC -> DONE after the iteration with count 31.
REQ-020 Latency, accept cycle = 0: normal div_done in cycle 33; special case div_done in cycle 1.
REQ-021 Signed fix-up is applied in DONE:
- Quotient is negated when the operand signs differ (DIV).
- Remainder takes the dividend's sign (REM).
- Unsigned ops need no fix-up.
REQ-022 In DONE: div_done=1, result and rd driven; DONE -> IDLE unconditionally.
REQ-023 div_start is ignored outside IDLE; a new op is accepted no earlier than the cycle after DONE.
REQ-024 flush=1 in any state -> IDLE on the next edge, with no div_done.
- flush has priority over accept and over DONE: div_done is forced to 0 in a flushed DONE cycle.
REQ-025 div_result and div_rd_o are 0 whenever div_done=0.

Reset
REQ-026 rst_n low asynchronously forces: state IDLE, counter 0, all datapath registers 0.
REQ-027 Outputs during and after reset: div_busy 0 (with div_start low), div_done 0, div_result 0, div_rd_o 0, div_wr_en_o 0.
REQ-028 Reset in CALC discards the op; no div_done follows release.

Structure
REQ-029 The shared defines file holds:
- div_op encodings;
- FSM state encodings;
- M-extension opcode/funct7 constants.
REQ-030 alu_div is a single module: FSM, counter and 64-bit remainder/quotient shift register; no sub-module.
REQ-031 The ALU decodes funct7=0000001 with funct3[2]=1 into div_start; ctrl ORs div_busy into its stall.

Verification
REQ-032 DIVU 100/7, start held -> div_busy high cycles 0-32; div_done cycle 33; result 14; div_rd_o = rd.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REMU 0xFFFFFFF9/2 -> 1; each done in cycle 33.
REQ-034 DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with div_done in cycle 1.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; done in cycle 1.
REQ-036 flush in CALC cycle 10 -> div_busy 0 next cycle, no div_done; a DIVU 9/3 started next cycle -> 3 after 33 cycles.
REQ-037 rst_n low in CALC cycle 20 -> immediate IDLE, all outputs 0, no div_done after release.
